hamming_secded_encoder_pipe: RTL and testbench

HAMMING_SECDED_ENCODER_PIPE -- requirements
Module: hamming_secded_encoder_pipe

---
 rtl/hamming_secded_encoder_pipe.sv | 145 ++++++++++++++
 tb/tb_hamming_secded_encoder_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_encoder_pipe.sv
// hamming_secded_encoder_pipe: two-stage elastic Hamming SEC / SECDED encoder.
// Stage 1 holds the data word, the injection mask and the Hamming parity bits.
// Stage 2 holds the finished (optionally overall-parity-extended) codeword
// with the injection mask applied. word_cnt counts delivered codewords.
module hamming_secded_encoder_pipe #(
  parameter int DATA_W = 16,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16,
  localparam int R = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 : 7,
  localparam int N = DATA_W + R + SECDED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [N-1:0]      in_inj_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_code,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int M = DATA_W + R;

  if (DATA_W < 4 || DATA_W > 64) begin : g_bad_data_w
    $error("hamming_secded_encoder_pipe: DATA_W must be in 4..64");
  end
  if (SECDED != 0 && SECDED != 1) begin : g_bad_secded
    $error("hamming_secded_encoder_pipe: SECDED must be 0 or 1");
  end

  // Position (1-based) of data bit j: the j-th position that is not a power of two.
  function automatic int data_pos(input int j);
    int pos;
    int k;
    pos = 0;
    k   = 0;
    for (int p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == j) pos = p;
        k++;
      end
    end
    return pos;
  endfunction

  // Data bits that feed parity P(2^i): those whose position has bit i set.
  function automatic logic [DATA_W-1:0] cover_mask(input int i);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int j = 0; j < DATA_W; j++) begin
      if (((data_pos(j) >> i) & 1) == 1) m[j] = 1'b1;
    end
    return m;
  endfunction

  logic              rdy_en_q;
  logic              s1_v_q, s1_v_d;
  logic              s2_v_q, s2_v_d;
  logic [DATA_W-1:0] s1_data_q;
  logic [N-1:0]      s1_mask_q;
  logic [R-1:0]      s1_par_q, par_d;
  logic [N-1:0]      s2_code_q, code_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [M-1:0]      ham;
  logic              s1_adv, in_fire, s2_load, out_fire;

  // Parity terms are computed on the input side so stage 2 only assembles.
  for (genvar gi = 0; gi < R; gi++) begin : g_par
    localparam logic [DATA_W-1:0] COV = cover_mask(gi);
    assign par_d[gi] = ^(in_data & COV);
  end

  for (genvar gj = 0; gj < DATA_W; gj++) begin : g_dmap
    localparam int P = data_pos(gj);
    assign ham[P-1] = s1_data_q[gj];
  end

  for (genvar gi = 0; gi < R; gi++) begin : g_pmap
    assign ham[(1 << gi) - 1] = s1_par_q[gi];
  end

  // Overall parity covers the clean Hamming word; the mask is applied last.
  if (SECDED == 1) begin : g_secded
    assign code_d = {^ham, ham} ^ s1_mask_q;
  end else begin : g_sec
    assign code_d = ham ^ s1_mask_q;
  end

  // rdy_en_q keeps in_ready low through reset and the cycle of its release.
  assign s1_adv     = !s2_v_q || out_ready;
  assign in_ready   = rdy_en_q && (!s1_v_q || s1_adv);
  assign in_fire    = in_valid && in_ready;
  assign s2_load    = s1_v_q && s1_adv;
  assign out_fire   = s2_v_q && out_ready;
  assign s1_v_d     = in_fire || (s1_v_q && !s1_adv);
  assign s2_v_d     = s2_load || (s2_v_q && !out_ready);
  assign word_cnt_d = out_fire ? word_cnt_q + CNT_W'(1) : word_cnt_q;

  assign out_valid = s2_v_q;
  assign out_code  = s2_code_q;
  assign word_cnt  = word_cnt_q;

  // Stage valid flags, ready enable and delivered-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Stage 1 captures a word only when it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q <= '0;
      s1_mask_q <= '0;
      s1_par_q  <= '0;
    end else if (in_fire) begin
      s1_data_q <= in_data;
      s1_mask_q <= in_inj_mask;
      s1_par_q  <= par_d;
    end
  end

  // Stage 2 captures the finished codeword only when stage 1 advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_code_q <= '0;
    end else if (s2_load) begin
      s2_code_q <= code_d;
    end
  end

endmodule

// File: tb/tb_hamming_secded_encoder_pipe.sv
// Directed bench for hamming_secded_encoder_pipe at DATA_W=16, SECDED=1.
module tb_hamming_secded_encoder_pipe;

  localparam int DW     = 16;
  localparam int NW     = 22;
  localparam int CW     = 16;
  localparam int NWORDS = 70000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [NW-1:0] in_inj_mask = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NW-1:0] out_code;
  logic [CW-1:0] word_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;

  always #5 clk = ~clk;

  hamming_secded_encoder_pipe #(
    .DATA_W(DW),
    .SECDED(1),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_inj_mask(in_inj_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .word_cnt   (word_cnt)
  );

  // Reference: place data, then solve each check equation over all positions.
  function automatic logic [NW-1:0] ref_code(input logic [DW-1:0] d, input logic [NW-1:0] m);
    int dpos [DW] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};
    logic [NW-2:0] h;
    logic p;
    h = '0;
    for (int j = 0; j < DW; j++) h[dpos[j]-1] = d[j];
    for (int i = 0; i < 5; i++) begin
      p = 1'b0;
      for (int q = 1; q <= NW - 1; q++) if (((q >> i) & 1) == 1) p = p ^ h[q-1];
      h[(1 << i) - 1] = p;
    end
    return {^h, h} ^ m;
  endfunction

  task automatic test_reset;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_code !== '0) begin miscompares++; $display("FAIL rst_out_code: got %h want 0", out_code); end
    vectors++; if (word_cnt !== '0) begin miscompares++; $display("FAIL rst_word_cnt: got %0d want 0", word_cnt); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_release_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_first_edge_in_ready: got %b want 1", in_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_encode;
    logic [DW-1:0] vd [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0001};
    logic [NW-1:0] vm [4] = '{22'h0, 22'h0, 22'h0, 22'h000004};
    logic [NW-1:0] ve [4] = '{22'h000000, 22'h200007, 22'h1FFFFE, 22'h200003};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = vd[k]; in_inj_mask = vm[k];
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL enc_in_ready[%0d]: got %b want 1", k, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 16'hDEAD; in_inj_mask = '1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL enc_early_valid[%0d]: got %b want 0", k, out_valid); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL enc_valid[%0d]: got %b want 1", k, out_valid); end
      vectors++; if (out_code !== ve[k]) begin miscompares++; $display("FAIL enc_code[%0d]: got %h want %h", k, out_code, ve[k]); end
      @(posedge clk); #1;
      exp_cnt++;
      vectors++; if (word_cnt !== CW'(exp_cnt)) begin miscompares++; $display("FAIL enc_word_cnt[%0d]: got %0d want %0d", k, word_cnt, exp_cnt); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL enc_drained[%0d]: got %b want 0", k, out_valid); end
    end
    in_inj_mask = '0;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] bw [4] = '{16'hA5A5, 16'h1234, 16'h8000, 16'h7FFF};
    int idx  = 0;
    int oidx = 0;
    int c    = 0;
    in_inj_mask = '0;
    while (oidx < 4 && c < 40) begin
      @(posedge clk); #1;
      in_valid  = (idx < 4);
      if (idx < 4) in_data = bw[idx];
      out_ready = (c >= 4);
      @(negedge clk);
      if (c == 2 || c == 3) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid c%0d: got %b want 1", c, out_valid); end
        vectors++; if (out_code !== ref_code(bw[0], '0)) begin miscompares++; $display("FAIL bp_hold c%0d: got %h want %h", c, out_code, ref_code(bw[0], '0)); end
      end
      if (c == 3) begin
        vectors++; if (idx !== 2) begin miscompares++; $display("FAIL bp_accepted: got %0d want 2", idx); end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        vectors++;
        if (out_code !== ref_code(bw[oidx], '0)) begin
          miscompares++; $display("FAIL bp_order[%0d]: got %h want %h", oidx, out_code, ref_code(bw[oidx], '0));
        end
        oidx++;
      end
      c++;
    end
    vectors++; if (oidx !== 4) begin miscompares++; $display("FAIL bp_timeout: got %0d words want 4", oidx); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_cnt += 4;
    vectors++; if (word_cnt !== CW'(exp_cnt)) begin miscompares++; $display("FAIL bp_word_cnt: got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_mid_reset;
    int stale = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = DW'(16'h0F0F + k);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mr_inflight: got %b want 1", out_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mr_out_valid: got %b want 0", out_valid); end
    vectors++; if (word_cnt !== '0) begin miscompares++; $display("FAIL mr_word_cnt: got %0d want 0", word_cnt); end
    vectors++; if (out_code !== '0) begin miscompares++; $display("FAIL mr_out_code: got %h want 0", out_code); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mr_in_ready: got %b want 0", in_ready); end
    exp_cnt = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    vectors++; if (stale !== 0) begin miscompares++; $display("FAIL mr_stale: got %0d stale cycles want 0", stale); end
    vectors++; if (word_cnt !== '0) begin miscompares++; $display("FAIL mr_word_cnt_after: got %0d want 0", word_cnt); end
  endtask

  task automatic test_stream;
    logic [NW-1:0] exp_q [$];
    int            cyc_q [$];
    logic [NW-1:0] e;
    int            ec;
    int            sent = 0;
    int            got  = 0;
    int            c    = 0;
    out_ready = 1'b1;
    while (got < NWORDS && c < NWORDS + 20) begin
      @(posedge clk); #1;
      in_valid    = (sent < NWORDS);
      in_data     = DW'($urandom);
      in_inj_mask = ($urandom_range(3, 0) == 0) ? (NW'(1) << $urandom_range(NW - 1, 0)) : '0;
      @(negedge clk);
      if (in_valid) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL st_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_code(in_data, in_inj_mask));
        cyc_q.push_back(c);
        sent++;
      end
      if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL st_spurious c%0d: got %h want no word", c, out_code);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          if (out_code !== e) begin miscompares++; $display("FAIL st_code[%0d]: got %h want %h", got, out_code, e); end
          vectors++;
          if (c - ec != 2) begin miscompares++; $display("FAIL st_latency[%0d]: got %0d want 2", got, c - ec); end
          got++;
        end
      end
      c++;
    end
    vectors++; if (got !== NWORDS) begin miscompares++; $display("FAIL st_timeout: got %0d words want %0d", got, NWORDS); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (word_cnt !== 16'd4464) begin miscompares++; $display("FAIL st_wrap: got %0d want 4464", word_cnt); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_backpressure();
    test_mid_reset();
    test_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
